// File: rtl/nn_seq_pkg.sv
// Shared types and defaults for the NN load sequencer.
// Holds the FSM state type, default widths and the watchdog state helper.
package nn_seq_pkg;

  localparam int unsigned LBITS_DEF   = 2;
  localparam int unsigned TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IMG_REQ    = 3'd1,
    IMG_WAIT   = 3'd2,
    COEF_REQ   = 3'd3,
    COEF_WAIT  = 3'd4,
    COMP_START = 3'd5,
    COMP_WAIT  = 3'd6,
    FINISH     = 3'd7
  } state_t;

  // States the watchdog is allowed to abort.
  function automatic logic is_timed(state_t s);
    return (s == IMG_REQ) || (s == IMG_WAIT) ||
           (s == COEF_REQ) || (s == COEF_WAIT);
  endfunction

endpackage

// File: rtl/nn_seq_timer.sv
// Watchdog cycle counter for the load sequencer.
// Ports: clock, reset_n (sync, active-low), clear, enable -> expired.
module nn_seq_timer
  import nn_seq_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  // Counts cycles spent in the current state; the LIMIT-th cycle
  // raises expired so the abort edge closes exactly LIMIT cycles.
  assign expired = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/nn_load_sequencer.sv
// Sequences image fetch, per-layer coefficient fetch and compute runs.
// Ports: clock, reset_n (sync, active-low), start, last_layer in;
//   get_image, get_coeffs, layer, compute_start, seq_busy, done, error out;
//   bus_busy, compute_done in. Macro NN_SEQ_TIMEOUT_EN adds a watchdog.
module nn_load_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned LBITS          = LBITS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LBITS-1:0] last_layer,
  output logic             get_image,
  output logic             get_coeffs,
  output logic [LBITS-1:0] layer,
  input  logic             bus_busy,
  output logic             compute_start,
  input  logic             compute_done,
  output logic             seq_busy,
  output logic             done,
  output logic             error
);

  state_t           state;
  state_t           next;
  logic [LBITS-1:0] cnt;
  logic [LBITS-1:0] last_q;
  logic             req_sent;
  logic             last_hit;
  logic             timeout;

  // A request first rises only on an idle bus, then holds until
  // the bus reports busy (req_sent remembers it was issued).
  assign get_image     = (state == IMG_REQ) &&
                         (req_sent || !bus_busy);
  assign get_coeffs    = (state == COEF_REQ) &&
                         (req_sent || !bus_busy);
  assign layer         = cnt;
  assign compute_start = (state == COMP_START);
  assign done          = (state == FINISH);
  assign seq_busy      = (state != IDLE);
  assign last_hit      = (cnt == last_q);

  always_comb begin
    next = state;
    unique case (state)
      IDLE:       if (start) next = IMG_REQ;
      IMG_REQ:    if (req_sent && bus_busy) next = IMG_WAIT;
      IMG_WAIT:   if (!bus_busy) next = COEF_REQ;
      COEF_REQ:   if (req_sent && bus_busy) next = COEF_WAIT;
      COEF_WAIT:  if (!bus_busy) next = COMP_START;
      COMP_START: next = COMP_WAIT;
      COMP_WAIT:  if (compute_done)
                    next = last_hit ? FINISH : COEF_REQ;
      FINISH:     next = IDLE;
      default:    next = IDLE;
    endcase
    if (timeout) next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_q   <= '0;
      req_sent <= 1'b0;
    end else begin
      state    <= next;
      req_sent <= (next == state) &&
                  (req_sent || get_image || get_coeffs);
      if ((state == IDLE) && start) begin
        cnt    <= '0;
        last_q <= last_layer;
      end else if (timeout || (state == FINISH)) begin
        cnt    <= '0;
      end else if ((state == COMP_WAIT) && compute_done &&
                   !last_hit) begin
        // Equality stops the walk, so the counter never wraps.
        cnt    <= cnt + LBITS'(1);
      end
    end
  end

`ifdef NN_SEQ_TIMEOUT_EN
  logic err_q;

  nn_seq_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (next != state),
    .enable  (is_timed(state)),
    .expired (timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign error = err_q;
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign error          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Directed bench for nn_load_sequencer with bus/compute responders.
// Define NN_SEQ_TIMEOUT_EN to also exercise the watchdog abort.
module tb_nn_load_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [1:0] last_layer;
  logic       get_image;
  logic       get_coeffs;
  logic [1:0] layer;
  logic       bus_busy;
  logic       compute_start;
  logic       compute_done;
  logic       seq_busy;
  logic       done;
  logic       error;

  int checks;
  int errors;

  logic       bus_auto;
  logic       comp_auto;
  int         busy_left;
  int         comp_left;
  logic       req_n;
  logic       cs_n;

  int         ev_img;
  int         ev_coef;
  int         ev_cs;
  int         ev_done;
  int         ev_err;
  int         ev_both;
  int         ev_unstable;
  logic       prev_img;
  logic       prev_coef;
  logic [1:0] prev_layer;
  logic [1:0] layers[$];

  nn_load_sequencer #(
    .LBITS          (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .last_layer    (last_layer),
    .get_image     (get_image),
    .get_coeffs    (get_coeffs),
    .layer         (layer),
    .bus_busy      (bus_busy),
    .compute_start (compute_start),
    .compute_done  (compute_done),
    .seq_busy      (seq_busy),
    .done          (done),
    .error         (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    ev_img  = 0;
    ev_coef = 0;
    ev_cs   = 0;
    ev_done = 0;
    ev_err  = 0;
    layers.delete();
  endtask

  function automatic int lay(input int i);
    if (i < layers.size()) return int'(layers[i]);
    return 99;
  endfunction

  // Called just after a negedge; start is sampled at the next edge.
  task automatic pulse_start(input logic [1:0] ll);
    start      = 1'b1;
    last_layer = ll;
    @(posedge clock);
    #1;
    start      = 1'b0;
    last_layer = 2'd0;
    @(negedge clock);
    #1;
    chk("accept", int'(seq_busy), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!seq_busy) break;
      @(negedge clock);
      #1;
    end
    chk("idle_budget", int'(seq_busy), 0);
  endtask

  // Monitor at negedge, responders just after posedge.
  initial begin
    forever begin
      @(negedge clock);
      if (get_image && !prev_img) ev_img++;
      if (get_coeffs && !prev_coef) begin
        ev_coef++;
        layers.push_back(layer);
      end
      if (get_coeffs && prev_coef && layer != prev_layer)
        ev_unstable++;
      if (compute_start) ev_cs++;
      if (done) ev_done++;
      if (error) ev_err++;
      if (get_image && get_coeffs) ev_both++;
      prev_img   = get_image;
      prev_coef  = get_coeffs;
      prev_layer = layer;
      req_n      = get_image | get_coeffs;
      cs_n       = compute_start;
      @(posedge clock);
      #1;
      if (bus_auto) begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus_busy = 1'b0;
        end else if (req_n) begin
          bus_busy  = 1'b1;
          busy_left = 3;
        end
      end
      if (comp_auto) begin
        compute_done = 1'b0;
        if (comp_left > 0) begin
          comp_left--;
          if (comp_left == 0) compute_done = 1'b1;
        end else if (cs_n) begin
          comp_left = 10;
        end
      end
    end
  end

  initial begin
    int k;
    logic bad;
    checks = 0; errors = 0;
    reset_n = 1'b0; start = 1'b0; last_layer = 2'd0;
    bus_busy = 1'b0; compute_done = 1'b0;
    bus_auto = 1'b1; comp_auto = 1'b1;
    busy_left = 0; comp_left = 0;
    prev_img = 1'b0; prev_coef = 1'b0; prev_layer = 2'd0;
    req_n = 1'b0; cs_n = 1'b0;
    ev_both = 0; ev_unstable = 0;
    clr();

    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_busy", int'(seq_busy), 0);
    chk("rst_img", int'(get_image), 0);
    chk("rst_coef", int'(get_coeffs), 0);
    chk("rst_layer", int'(layer), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(error), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    #1;

    // Three layers, image fetched once.
    clr();
    pulse_start(2'd2);
    wait_idle(2000);
    chk("l2_img", ev_img, 1);
    chk("l2_coef", ev_coef, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("l2_lay%0d", i), lay(i), i);
    chk("l2_cs", ev_cs, 3);
    chk("l2_done", ev_done, 1);

    // Start in the first idle cycle after done; all-ones layer.
    clr();
    pulse_start(2'd3);
    wait_idle(2000);
    chk("l3_coef", ev_coef, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("l3_lay%0d", i), lay(i), i);
    chk("l3_cs", ev_cs, 4);
    chk("l3_done", ev_done, 1);

    // Busy bus at start holds get_image low.
    clr();
    bus_auto = 1'b0;
    bus_busy = 1'b1;
    pulse_start(2'd0);
    bad = get_image;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      bad = bad | get_image;
    end
    chk("img_held", int'(bad), 0);
    @(posedge clock);
    #1;
    bus_busy = 1'b0;
    @(negedge clock);
    #1;
    chk("img_rise", int'(get_image), 1);
    bus_auto = 1'b1;
    wait_idle(2000);
    chk("bb_img", ev_img, 1);
    chk("bb_done", ev_done, 1);

    // Stray start in COMP_WAIT, stray compute_done in IDLE.
    clr();
    pulse_start(2'd1);
    for (int i = 0; i < 200 && ev_cs == 0; i++) begin
      @(negedge clock);
      #1;
    end
    chk("cw_reach", ev_cs, 1);
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    #1;
    chk("cw_img", int'(get_image), 0);
    chk("cw_cs", int'(compute_start), 0);
    chk("cw_layer", int'(layer), 0);
    wait_idle(2000);
    chk("cw_nimg", ev_img, 1);
    chk("cw_ncs", ev_cs, 2);
    chk("cw_done", ev_done, 1);
    comp_auto = 1'b0;
    @(posedge clock);
    #1;
    compute_done = 1'b1;
    @(posedge clock);
    #1;
    compute_done = 1'b0;
    @(negedge clock);
    #1;
    comp_auto = 1'b1;
    chk("sp_busy", int'(seq_busy), 0);
    chk("sp_cs", ev_cs, 2);

    // Reset in COEF_WAIT of layer 1, then restart.
    clr();
    pulse_start(2'd2);
    for (int i = 0; i < 500; i++) begin
      if (ev_coef == 2 && !get_coeffs && bus_busy) break;
      @(negedge clock);
      #1;
    end
    chk("cwait_reach", ev_coef, 2);
    reset_n = 1'b0;
    @(negedge clock);
    #1;
    chk("mr_busy", int'(seq_busy), 0);
    chk("mr_img", int'(get_image), 0);
    chk("mr_coef", int'(get_coeffs), 0);
    chk("mr_cs", int'(compute_start), 0);
    chk("mr_done", int'(done), 0);
    chk("mr_err", int'(error), 0);
    chk("mr_layer", int'(layer), 0);
    repeat (5) @(negedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    clr();
    pulse_start(2'd0);
    wait_idle(2000);
    chk("rs_img", ev_img, 1);
    chk("rs_lay0", lay(0), 0);
    chk("rs_done", ev_done, 1);

    // Bus never answers.
    clr();
    bus_auto = 1'b0;
    bus_busy = 1'b0;
    pulse_start(2'd0);
`ifdef NN_SEQ_TIMEOUT_EN
    k = 1;
    while (k < 40 && !error) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("to_lat", k, 17);
    chk("to_busy", int'(seq_busy), 0);
    chk("to_img", int'(get_image), 0);
    @(negedge clock);
    #1;
    chk("to_pulse", int'(error), 0);
    chk("to_nerr", ev_err, 1);
    chk("to_done", ev_done, 0);
`else
    k = 0;
    repeat (40) @(negedge clock);
    #1;
    chk("nt_err", ev_err, 0);
    chk("nt_busy", int'(seq_busy), 1);
    chk("nt_img", int'(get_image), 1);
    reset_n = 1'b0;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    chk("nt_rst", int'(seq_busy) + k, 0);
`endif
    bus_auto = 1'b1;

    chk("excl", ev_both, 0);
    chk("stable", ev_unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
